// File: rtl/cram_if.sv
// Pin bundle for an asynchronous cellular-RAM device pair sharing one bus.
// The multiplexed address/data lines (dq) stay a separate inout port.
interface cram_if #(
    parameter int A_W = 6
);
    logic [A_W-1:0] a;
    logic           clk;
    logic           cre;
    logic           adv_n;
    logic           ce0_n;
    logic           ce1_n;
    logic           oe_n;
    logic           we_n;
    logic           lb_n;
    logic           ub_n;

    modport master (
        output a, clk, cre, adv_n, ce0_n, ce1_n, oe_n, we_n, lb_n, ub_n
    );

    modport slave (
        input a, clk, cre, adv_n, ce0_n, ce1_n, oe_n, we_n, lb_n, ub_n
    );
endinterface

// File: rtl/psram_multiport.sv
// Round-robin multi-port controller for an async PSRAM pair, one access at a time.
// Optional per-byte write masking: define PSRAM_MULTIPORT_WRITE_MASK_EN.
module psram_multiport #(
    parameter int CLK_FREQ        = 74250000,
    parameter int NUM_PORTS       = 2,
    parameter int ADDRESS_BITS    = 23,
    parameter int DATA_BITS       = 16,
    parameter int RAM_CYCLE_NANOS = 72,
    parameter int MIN_GAP_CYCLES  = 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_PORTS-1:0]              req_valid,
    input  logic [NUM_PORTS-1:0]              req_write,
    input  logic [NUM_PORTS*ADDRESS_BITS-1:0] req_address,
    input  logic [NUM_PORTS*DATA_BITS-1:0]    req_wdata,
    input  logic [NUM_PORTS*2-1:0]            req_be,
    output logic [NUM_PORTS-1:0]              req_ready,
    output logic [NUM_PORTS-1:0]              rsp_valid,
    output logic [DATA_BITS-1:0]              rsp_data,
    cram_if.master                            cram,
    inout  wire  [DATA_BITS-1:0]              cram_dq
);

    // CE#-low cycles per access, rounded up; 64-bit product avoids overflow.
    localparam longint CYC_PROD = longint'(RAM_CYCLE_NANOS) * longint'(CLK_FREQ);
    localparam longint CYC_CEIL = (CYC_PROD + 64'd999_999_999) / 64'd1_000_000_000;
    localparam int     N        = (CYC_CEIL < 3) ? 3 : int'(CYC_CEIL);
    localparam int     CNT_W    = $clog2(N + 1);
    localparam int     PTR_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int     GAP_W    = 3;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_HOLD    = 3'd2;
    localparam logic [2:0] S_ACCESS  = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    logic [2:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic [GAP_W-1:0]        gap;
    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        port_q;
    logic                    write_q;
    logic [ADDRESS_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0]    wdata_q;

    logic [PTR_W-1:0]        grant;
    logic                    grant_hit;
    logic [PTR_W-1:0]        grant_next;
    logic                    ce_low;
    logic                    oe_n_int;
    logic [DATA_BITS-1:0]    dq_out;

    logic [ADDRESS_BITS-1:0] addr_arr  [NUM_PORTS];
    logic [DATA_BITS-1:0]    wdata_arr [NUM_PORTS];
    logic [1:0]              be_arr    [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign addr_arr[p]  = req_address[p*ADDRESS_BITS +: ADDRESS_BITS];
        assign wdata_arr[p] = req_wdata[p*DATA_BITS +: DATA_BITS];
        assign be_arr[p]    = req_be[p*2 +: 2];
    end

    // First valid port at or after rr_ptr, wrapping.
    always_comb begin
        grant     = '0;
        grant_hit = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            int               idx;
            logic [PTR_W-1:0] idx_p;
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            idx_p = PTR_W'(idx);
            if (!grant_hit && req_valid[idx_p]) begin
                grant_hit = 1'b1;
                grant     = idx_p;
            end
        end
    end

    assign grant_next = (grant == PTR_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        req_ready = '0;
        if (reset_n && state == S_IDLE && grant_hit) req_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            gap       <= '0;
            rr_ptr    <= '0;
            port_q    <= '0;
            write_q   <= 1'b0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (grant_hit) begin
                        state   <= S_ADDR;
                        cnt     <= CNT_W'(1);
                        port_q  <= grant;
                        write_q <= req_write[grant];
                        rr_ptr  <= grant_next;
                    end
                end
                S_ADDR: begin
                    cnt   <= cnt + 1'b1;
                    state <= write_q ? S_HOLD : S_ACCESS;
                end
                S_HOLD: begin
                    cnt   <= cnt + 1'b1;
                    state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (cnt == CNT_W'(N)) begin
                        if (!write_q) begin
                            rsp_valid[port_q] <= 1'b1;
                            rsp_data          <= cram_dq;
                        end
                        gap   <= GAP_W'(1);
                        state <= (MIN_GAP_CYCLES == 0) ? S_IDLE : S_RECOVER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RECOVER: begin
                    if (gap == GAP_W'(MIN_GAP_CYCLES)) state <= S_IDLE;
                    else gap <= gap + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Request payload is captured on acceptance only; no reset needed.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && grant_hit) begin
            addr_q  <= addr_arr[grant];
            wdata_q <= wdata_arr[grant];
        end
    end

`ifdef PSRAM_MULTIPORT_WRITE_MASK_EN
    logic [1:0] be_q;

    always_ff @(posedge clk) begin
        if (state == S_IDLE && grant_hit) be_q <= be_arr[grant];
    end
`else
    logic unused_be;
    assign unused_be = ^req_be ^ be_arr[0][0];
`endif

    assign ce_low   = (state == S_ADDR) || (state == S_HOLD) || (state == S_ACCESS);
    assign oe_n_int = !(state == S_ACCESS && !write_q);

    always_comb begin
        cram.ce0_n = !(ce_low && !addr_q[ADDRESS_BITS-1]);
        cram.ce1_n = !(ce_low &&  addr_q[ADDRESS_BITS-1]);
        cram.adv_n = (state != S_ADDR);
        cram.we_n  = !(ce_low && write_q);
        cram.oe_n  = oe_n_int;
        cram.lb_n  = 1'b1;
        cram.ub_n  = 1'b1;
        if (ce_low) begin
`ifdef PSRAM_MULTIPORT_WRITE_MASK_EN
            cram.lb_n = write_q ? ~be_q[0] : 1'b0;
            cram.ub_n = write_q ? ~be_q[1] : 1'b0;
`else
            cram.lb_n = 1'b0;
            cram.ub_n = 1'b0;
`endif
        end
    end

    assign cram.a   = addr_q[ADDRESS_BITS-2:DATA_BITS];
    assign cram.clk = 1'b0;
    assign cram.cre = 1'b0;

    // The bus is ours whenever the device output is disabled, except in reset.
    assign dq_out  = (state == S_ACCESS && write_q) ? wdata_q : addr_q[DATA_BITS-1:0];
    assign cram_dq = (reset_n && oe_n_int) ? dq_out : {DATA_BITS{1'bz}};

endmodule

// File: doc/psram_multiport.md
# psram_multiport

Multi-requester controller for one asynchronous PSRAM device pair (two banks on a shared bus) driving `cram_if` plus `cram_dq`. It arbitrates NUM_PORTS independent read/write request channels round-robin, runs one asynchronous access at a time with a cycle count derived from the clock frequency, and enforces a CE# recovery gap between accesses. Per-byte write masking is optional. It sits between core-side memory clients (video fetch, CPU, DMA) and the top-level cartridge-RAM pins.

## Interface
- CLK_FREQ, 74250000: clk frequency in Hz.
- NUM_PORTS, 2: requester channels, 1..8.
- ADDRESS_BITS, 23: word address bits; MSB selects bank.
- DATA_BITS, 16: word width.
- RAM_CYCLE_NANOS, 72: minimum CE#-low access time, including 2 ns of IOBUF delay.
- MIN_GAP_CYCLES, 1: CE#-high cycles after each access, 0..7.

Ports:
- clk  in  1  the single clock for the block.
- reset_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_PORTS  per-port request.
- req_write  in  NUM_PORTS  1 = write, 0 = read.
- req_address  in  NUM_PORTS*ADDRESS_BITS  port p at [p*ADDRESS_BITS +: ADDRESS_BITS].
- req_wdata  in  NUM_PORTS*DATA_BITS  write data.
- req_be  in  NUM_PORTS*2  byte enables; bit0 = low byte.
- req_ready  out  NUM_PORTS  accept strobe.
- rsp_valid  out  NUM_PORTS  one-cycle read-data strobe.
- rsp_data  out  DATA_BITS  read data, shared by all ports.
- cram  interface  cram_if  PSRAM control and address pins.
- cram_dq  inout  DATA_BITS  multiplexed address/data bus.

## Operation
- N = max(3, ceil(RAM_CYCLE_NANOS * CLK_FREQ / 1e9)), computed at elaboration. Counter width = $clog2(N+1).
- States: IDLE, ADDR, HOLD, ACCESS, RECOVER.
- IDLE: the grant goes to the first port with req_valid, searching from rr_ptr upward with wrap. req_ready[grant] is high combinationally; all other ready bits are low. When valid and ready are both high, the block latches the port, write flag, address, data and be, sets rr_ptr = grant+1 mod NUM_PORTS, and moves to ADDR.
- ADDR: 1 cycle. CE# low on the bank given by address MSB. ADV# low. WE# low if write. dq drives address[DATA_BITS-1:0].
- Next state after ADDR is HOLD for a write and ACCESS for a read.
- HOLD (write only): 1 cycle. ADV# high. WE# low. dq still drives the address.
- ACCESS:
  - Read: OE# low and dq is hi-Z.
  - Write: WE# low and dq drives the write data.
  - Exits when total CE#-low cycles reach N.
- RECOVER: CE# high for MIN_GAP_CYCLES, then IDLE. If MIN_GAP_CYCLES = 0, go directly to IDLE.
- cram.a = address[ADDRESS_BITS-2:DATA_BITS]. cram.clk = 0. cram.cre = 0.
- Reads: lb_n and ub_n are both low while CE# is low.
- dq is driven whenever OE# is high; otherwise it is hi-Z.
- A request that is not accepted must be held by the requester. The block queues nothing.

## Timing
- Acceptance at cycle T: CE# is low for cycles T+1 .. T+N.
- Read: dq is registered at the end of cycle T+N. rsp_valid[port] is high in cycle T+N+1 only. rsp_data holds its value until the next read response.
- Write: no response. Completion is implied.
- Throughput: 1 + N + MIN_GAP_CYCLES cycles per access.
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_data = 0.
  - CE0#, CE1#, WE#, OE#, ADV#, LB#, UB# = 1.
  - dq = hi-Z, rr_ptr = 0.
- Reset mid-access: the access is aborted immediately and asynchronously. CE# goes high and no rsp_valid is produced.
- Port holding valid continuously with NUM_PORTS = 1: accepted every 1+N+MIN_GAP_CYCLES cycles.
- All ports valid at once: served in order rr_ptr, rr_ptr+1, ... No port waits more than NUM_PORTS-1 accesses.

## Configuration
- PSRAM_MULTIPORT_WRITE_MASK_EN defined: during writes, lb_n = ~be[0] and ub_n = ~be[1] for the whole CE#-low window. A write with be = 0 still runs the full cycle.
- Not defined: req_be is ignored and lb_n = ub_n = 0 on every access.

## Test plan
- N and read latency:
  - Stimulus: CLK_FREQ=74.25 MHz (N=6). Port 0 reads 0x000123 in cycle T.
  - Required: CE0# low for T+1..T+6, dq = 0x0123 in T+1, rsp_valid[0] in T+7, rsp_data equal to the model word.
- Write sequence:
  - Stimulus: port 1 writes 0x400010 with data 0xBEEF.
  - Required: CE1# low for 6 cycles, dq = 0x0010 for two cycles then 0xBEEF for four, WE# low throughout, ADV# low in the first cycle only.
- Round-robin:
  - Stimulus: NUM_PORTS=3, all ports valid continuously.
  - Required: grants 0,1,2,0,1,2. Acceptances spaced 8 cycles apart with MIN_GAP_CYCLES=1.
- Byte mask:
  - Stimulus: PSRAM_MULTIPORT_WRITE_MASK_EN defined, write with be=2'b10.
  - Required: lb_n = 1, ub_n = 0. A read-back shows only the high byte changed.
  - Without the macro, the same stimulus gives lb_n = ub_n = 0.
- Reset mid-read:
  - Stimulus: assert reset_n low at cycle T+3 of a read.
  - Required: CE# high in the same cycle, rsp_valid never asserted, and the first grant after release goes to port 0.
